// File: rtl/dice_pkg.sv
// Shared definitions for the dice-game sum interface: FSM encoding, widths,
// LFSR feedback mask and the per-cycle die tumble step.
package dice_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROLL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DIE_W   = 3;
  localparam int SUM_W   = 4;
  localparam int DIE_MAX = 6;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Advance a face by 1..4 with wrap; a 4-bit intermediate keeps 6+4 from overflowing.
  function automatic logic [DIE_W-1:0] die_step(input logic [DIE_W-1:0] die,
                                                input logic [1:0]       rnd);
    logic [3:0] t;
    t = {1'b0, die} + {2'b00, rnd} + 4'd1;
    if (t > 4'(DIE_MAX)) t = t - 4'(DIE_MAX);
    return DIE_W'(t);
  endfunction

endpackage

// File: rtl/dice_lfsr16.sv
// Free-running 16-bit Galois LFSR; an all-zero seed is replaced so the
// register can never lock up.
module dice_lfsr16
  import dice_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else if (state[0]) state <= (state >> 1) ^ LFSR_MASK;
    else state <= state >> 1;
  end

endmodule

// File: rtl/dice_roller.sv
// Two-dice roller: synchronized button edge starts a tumble of ROLL_CYCLES
// cycles, then presents the sum with a one-cycle valid strobe.
// Optional input debounce is enabled with the DICE_DEBOUNCE_EN macro.
module dice_roller
  import dice_pkg::*;
#(
  parameter int          ROLL_CYCLES     = 16,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             roll_en,
  output logic [DIE_W-1:0] die_a,
  output logic [DIE_W-1:0] die_b,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(ROLL_CYCLES + 1);

  logic [15:0]      lfsr;
  logic [1:0]       sync;
  logic             level;
  logic             level_d;
  logic             btn_rise;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [DIE_W-1:0] next_a;
  logic [DIE_W-1:0] next_b;
  logic             unused_lfsr;

  dice_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b00;
    else sync <= {sync[0], btn};
  end

`ifdef DICE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;

  // The debounced level only follows after an uninterrupted run of the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (sync[1] == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      level  <= sync[1];
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;

  assign level = sync[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d  <= 1'b0;
      btn_rise <= 1'b0;
    end else begin
      level_d  <= level;
      btn_rise <= level & ~level_d;
    end
  end

  assign next_a = die_step(die_a, lfsr[1:0]);
  assign next_b = die_step(die_b, lfsr[3:2]);

  // The sum is captured alongside the final tumble so it is already stable in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      die_a <= DIE_W'(1);
      die_b <= DIE_W'(1);
      sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_rise && roll_en) begin
            state <= ROLL;
            cnt   <= CNT_W'(ROLL_CYCLES - 1);
          end
        end
        ROLL: begin
          die_a <= next_a;
          die_b <= next_b;
          if (cnt == '0) begin
            state <= DONE;
            sum   <= SUM_W'(next_a) + SUM_W'(next_b);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign sum_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller with ROLL_CYCLES=4; the debounce scenario
// runs only when DICE_DEBOUNCE_EN is defined.
module tb_dice_roller;

  localparam int RC = 4;
`ifdef DICE_DEBOUNCE_EN
  localparam int DB     = 8;
  localparam int LAT    = DB + 12;
  localparam int SETTLE = DB + 6;
  localparam int ROLLS  = 1000;
`else
  localparam int DB     = 1000;
  localparam int LAT    = 10;
  localparam int SETTLE = 6;
  localparam int ROLLS  = 3000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       btn;
  logic       roll_en;
  logic [2:0] die_a;
  logic [2:0] die_b;
  logic [3:0] sum;
  logic       sum_valid;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dice_roller #(
    .ROLL_CYCLES     (RC),
    .LFSR_SEED       (16'hACE1),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .roll_en   (roll_en),
    .die_a     (die_a),
    .die_b     (die_b),
    .sum       (sum),
    .sum_valid (sum_valid),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    btn = 1'b0;
    repeat (SETTLE) tick();
  endtask

  task automatic wait_busy(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      if (busy) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    checks += 5;
    if (die_a !== 3'd1) begin errors++; $display("FAIL reset_die_a: got %0d expected 1", die_a); end
    if (die_b !== 3'd1) begin errors++; $display("FAIL reset_die_b: got %0d expected 1", die_b); end
    if (sum !== 4'd0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", sum); end
    if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid: got %b expected 0", sum_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    $display("reset: die_a=%0d die_b=%0d sum=%0d busy=%b", die_a, die_b, sum, busy);
    repeat (2) tick();
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_roll;
    int n, busy_len, sv_cnt, sv_pos;
    bit ok;
    logic [3:0] sv_sum, sv_exp;
    logic [2:0] a, b;
    logic [3:0] s;
    roll_en = 1'b1;
    btn     = 1'b1;
    wait_busy(n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL roll_start: busy not seen within %0d cycles", LAT); end
`ifndef DICE_DEBOUNCE_EN
    checks++;
    if (n != 4) begin errors++; $display("FAIL roll_latency: busy after %0d cycles expected 4", n); end
`endif
    roll_en  = 1'b0;
    busy_len = 0;
    sv_cnt   = 0;
    sv_pos   = -1;
    sv_sum   = 4'd0;
    sv_exp   = 4'd15;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      if (busy) busy_len++;
      if (sum_valid) begin
        sv_cnt++;
        sv_pos = k;
        sv_sum = sum;
        sv_exp = {1'b0, die_a} + {1'b0, die_b};
      end
    end
    checks += 5;
    if (busy_len != RC + 1) begin errors++; $display("FAIL roll_busy_len: got %0d expected %0d", busy_len, RC + 1); end
    if (sv_cnt != 1) begin errors++; $display("FAIL roll_valid_count: got %0d expected 1", sv_cnt); end
    if (sv_pos != RC) begin errors++; $display("FAIL roll_valid_pos: got %0d expected %0d", sv_pos, RC); end
    if (sv_sum !== sv_exp) begin errors++; $display("FAIL roll_sum: got %0d expected %0d", sv_sum, sv_exp); end
    if (sv_sum < 4'd2 || sv_sum > 4'd12) begin errors++; $display("FAIL roll_sum_range: got %0d expected 2..12", sv_sum); end
    $display("roll: die_a=%0d die_b=%0d sum=%0d busy_len=%0d", die_a, die_b, sv_sum, busy_len);
    a = die_a; b = die_b; s = sum;
    btn = 1'b0;
    repeat (6) tick();
    checks++;
    if (die_a !== a || die_b !== b || sum !== s) begin
      errors++;
      $display("FAIL roll_hold: got %0d/%0d/%0d expected %0d/%0d/%0d", die_a, die_b, sum, a, b, s);
    end
    settle();
  endtask

  task automatic test_disabled;
    bit saw_busy, saw_sv;
    logic [3:0] s;
    s        = sum;
    saw_busy = 1'b0;
    saw_sv   = 1'b0;
    roll_en  = 1'b0;
    btn      = 1'b1;
    for (int i = 0; i < LAT + 10; i++) begin
      tick();
      if (i == LAT - 2) btn = 1'b0;
      if (busy) saw_busy = 1'b1;
      if (sum_valid) saw_sv = 1'b1;
    end
    checks += 3;
    if (saw_busy) begin errors++; $display("FAIL disabled_busy: got 1 expected 0"); end
    if (saw_sv) begin errors++; $display("FAIL disabled_valid: got 1 expected 0"); end
    if (sum !== s) begin errors++; $display("FAIL disabled_sum: got %0d expected %0d", sum, s); end
    $display("disabled: busy_seen=%b valid_seen=%b sum=%0d", saw_busy, saw_sv, sum);
    settle();
  endtask

  task automatic test_back_to_back;
    int n, sv_cnt;
    bit ok;
    roll_en = 1'b1;
    btn     = 1'b1;
    wait_busy(n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_start: busy not seen within %0d cycles", LAT); end
    btn = 1'b0;
    tick();
    btn    = 1'b1;
    sv_cnt = 0;
    for (int i = 0; i < LAT + 15; i++) begin
      tick();
      if (sum_valid) sv_cnt++;
    end
    checks++;
    if (sv_cnt != 1) begin errors++; $display("FAIL b2b_second_edge: got %0d valids expected 1", sv_cnt); end
    $display("back_to_back: valids=%0d", sv_cnt);
    settle();
    btn    = 1'b1;
    sv_cnt = 0;
    repeat (100) begin
      tick();
      if (sum_valid) sv_cnt++;
    end
    checks++;
    if (sv_cnt != 1) begin errors++; $display("FAIL held_button: got %0d valids expected 1", sv_cnt); end
    $display("held: valids=%0d", sv_cnt);
    settle();
  endtask

  task automatic test_reset_mid_roll;
    int n, sv_cnt;
    bit ok;
    roll_en = 1'b1;
    btn     = 1'b1;
    wait_busy(n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_start: busy not seen within %0d cycles", LAT); end
    tick();
    #2 reset = 1'b1;
    btn = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    if (sum_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", sum_valid); end
    if (sum !== 4'd0) begin errors++; $display("FAIL midreset_sum: got %0d expected 0", sum); end
    if (die_a !== 3'd1 || die_b !== 3'd1) begin
      errors++;
      $display("FAIL midreset_dice: got %0d/%0d expected 1/1", die_a, die_b);
    end
    #2 reset = 1'b0;
    sv_cnt = 0;
    repeat (10) begin
      tick();
      if (sum_valid) sv_cnt++;
    end
    checks += 2;
    if (sv_cnt != 0) begin errors++; $display("FAIL midreset_no_valid: got %0d expected 0", sv_cnt); end
    if (sum !== 4'd0) begin errors++; $display("FAIL midreset_sum_after: got %0d expected 0", sum); end
    $display("reset_mid_roll: busy=%b sum=%0d valids=%0d", busy, sum, sv_cnt);
    settle();
  endtask

  task automatic test_statistics;
    logic [6:1] seen_a, seen_b;
    int bad, done;
    bit got;
    seen_a  = '0;
    seen_b  = '0;
    bad     = 0;
    done    = 0;
    roll_en = 1'b1;
    for (int r = 0; r < ROLLS; r++) begin
      btn = 1'b1;
      got = 1'b0;
      for (int i = 0; i < LAT + RC + 4; i++) begin
        tick();
        if (sum_valid) begin got = 1'b1; break; end
      end
      if (!got) begin
        errors++;
        $display("FAIL stats_timeout: roll %0d produced no sum_valid", r);
        break;
      end
      done++;
      if (die_a >= 3'd1 && die_a <= 3'd6) seen_a[die_a] = 1'b1;
      if (die_b >= 3'd1 && die_b <= 3'd6) seen_b[die_b] = 1'b1;
      if (die_a < 3'd1 || die_a > 3'd6 || die_b < 3'd1 || die_b > 3'd6 ||
          sum < 4'd2 || sum > 4'd12 || sum !== ({1'b0, die_a} + {1'b0, die_b})) bad++;
      settle();
    end
    checks += 3;
    if (seen_a !== 6'b111111) begin errors++; $display("FAIL stats_faces_a: got %b expected 111111", seen_a); end
    if (seen_b !== 6'b111111) begin errors++; $display("FAIL stats_faces_b: got %b expected 111111", seen_b); end
    if (bad != 0) begin errors++; $display("FAIL stats_range: got %0d bad rolls expected 0", bad); end
    $display("statistics: rolls=%0d faces_a=%b faces_b=%b bad=%0d", done, seen_a, seen_b, bad);
  endtask

`ifdef DICE_DEBOUNCE_EN
  task automatic test_debounce;
    bit saw_busy;
    int sv_cnt;
    settle();
    roll_en  = 1'b1;
    saw_busy = 1'b0;
    btn      = 1'b1;
    repeat (5) tick();
    btn = 1'b0;
    repeat (30) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy) begin errors++; $display("FAIL debounce_glitch: got a roll expected none"); end
    sv_cnt = 0;
    btn    = 1'b1;
    repeat (20) begin
      tick();
      if (sum_valid) sv_cnt++;
    end
    btn = 1'b0;
    repeat (30) begin
      tick();
      if (sum_valid) sv_cnt++;
    end
    checks++;
    if (sv_cnt != 1) begin errors++; $display("FAIL debounce_press: got %0d valids expected 1", sv_cnt); end
    $display("debounce: glitch_roll=%b press_valids=%0d", saw_busy, sv_cnt);
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    btn     = 1'b0;
    roll_en = 1'b0;
    test_reset();
    test_roll();
    test_disabled();
    test_back_to_back();
    test_reset_mid_roll();
    test_statistics();
`ifdef DICE_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
